dec_sync_ctrl: RTL
==================

# dec_sync_ctrl

Link-synchronisation controller that sits directly downstream of the 8b/10b decoder. It qualifies decoded symbols, runs the comma-based acquire/lose-sync state machine, and owns the running-disparity feedback register that drives the decoder's `rdispin`. It emits clean data/control characters and link status to the receive framer, and maintains an optional saturating error counter.

## Interface
- `COMMA_CNT`, 3: consecutive-valid commas (K28.5) required to acquire sync.
- `ERR_THRESH`, 4: bad-symbol credit that drops sync.
- `GOOD_CNT`, 4: consecutive valid symbols that retire one bad-symbol credit.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `sym_valid` input 1: decoder outputs carry a new symbol this cycle.
- `datout` input 8: decoded byte from the decoder.
- `kout` input 1: decoded symbol is a K character.
- `code_err` input 1: decoder code violation.
- `disp_err` input 1: decoder disparity violation.
- `rdispout` input 1: decoder running disparity after the symbol.
- `rdispin` output 1: running disparity fed back to the decoder.
- `rx_data` output 8: qualified byte.
- `rx_k` output 1: qualified byte is a K character.
- `rx_valid` output 1: `rx_data`/`rx_k` valid.
- `sync_ok` output 1: link synchronised.
- `sync_state` output 2: FSM state code.
- `err_clr` input 1: synchronous clear of `err_cnt`.
- `err_cnt` output 16: saturating invalid-symbol count.

## Operation
- Invalid symbol: `sym_valid & (code_err | disp_err)`. Comma: `sym_valid & kout & datout==8'hBC & !invalid`.
- FSM states: LOS=2'd0, CDET=2'd1, SYNC=2'd2. 2'd3 is unused and recovers to LOS.
- LOS: on a comma, go to CDET with `comma_cnt=1`. Ignore everything else.
- CDET: an invalid symbol returns to LOS. A comma increments `comma_cnt`; when it reaches `COMMA_CNT`, go to SYNC. A valid non-comma holds state.
- SYNC: `bad_cnt` and `good_run` start at 0 on entry.
  - An invalid symbol increments `bad_cnt` and clears `good_run`.
  - A valid symbol increments `good_run`. When `good_run` reaches `GOOD_CNT` and `bad_cnt>0`, decrement `bad_cnt` and clear `good_run`.
  - When `bad_cnt` reaches `ERR_THRESH`, go to LOS.
- Running disparity: `rd_q` loads `rdispout` on each valid `sym_valid` cycle and holds on invalid symbols. `rd_q` is forced to 0 (RD−) on entry to LOS. `rdispin = rd_q`.
- Output path: `rx_valid` is 1 only for a valid symbol accepted while the state is SYNC, including the symbol that completes acquisition.
- Counter widths: `comma_cnt`, `bad_cnt` and `good_run` are sized `$clog2(param+1)` and saturate at their parameter value.

## Timing
- All outputs are registered. Reset values: `rdispin=0`, `rx_data=0`, `rx_k=0`, `rx_valid=0`, `sync_ok=0`, `sync_state=LOS`, `err_cnt=0`.
- Latency: a symbol presented in cycle N appears on `rx_*` in cycle N+1. `sync_ok`/`sync_state` reflect that symbol's transition in N+1.
- The symbol that drops SYNC→LOS has `rx_valid=0`. `sync_ok` falls in the same cycle.
- `sym_valid=0` cycles change no state or counter. `rx_valid` is 0 in those cycles.
- Reset asserted mid-operation returns everything to reset values asynchronously. The first edge after deassertion behaves as from LOS.
- `err_clr` and an increment in the same cycle give `err_cnt=1`. `err_cnt` saturates at 16'hFFFF.

## Configuration
- `DEC_SYNC_ERR_CNT_EN`:
  - When defined, `err_cnt` counts invalid symbols in any state and `err_clr` is honoured.
  - When undefined, no counter logic exists, `err_cnt` is tied to 0 and `err_clr` is ignored.

## Structure
- Shared package `dec_sync_pkg` holds:
  - the state enum (LOS/CDET/SYNC);
  - `K28_5_BYTE=8'hBC`;
  - the default values of `COMMA_CNT`, `ERR_THRESH` and `GOOD_CNT`.
- One natural sub-module, `dec_sync_errcnt`: the 16-bit saturating counter with clear, instantiated under the macro.

## Test plan
- Reset then 3 valid K28.5 symbols (`datout=8'hBC`, `kout=1`) -> `sync_state` goes 1, 1, 2. `sync_ok=1` one cycle after the third comma; `rx_valid=1` with `rx_data=8'hBC`, `rx_k=1` for the third.
- Two commas, then `code_err=1` -> state returns to LOS (0), `rdispin=0`, `rx_valid` stays 0.
- In SYNC, 4 isolated invalid symbols separated by 2 valid data -> the 4th drops to LOS, `sync_ok=0` the next cycle, no `rx_valid` on the errors.
- In SYNC, 3 invalid symbols, then 4 valid, then 1 invalid -> `bad_cnt` goes 3→2→3 and link stays in SYNC.
- `rdispout` toggling 1, 0, 1 on valid symbols, with one `disp_err` symbol that has `rdispout=0` -> `rdispin` tracks 1, 0, 1 and holds 1 across the error symbol.
- With `DEC_SYNC_ERR_CNT_EN`: 5 invalid symbols then `err_clr` coincident with a 6th -> `err_cnt` reads 5, then 1. Without the macro, `err_cnt` stays 0.

Source files
------------

// File: rtl/dec_sync_pkg.sv
// Shared types and defaults for the 8b/10b link-sync controller.
package dec_sync_pkg;

  typedef enum logic [1:0] {
    ST_LOS  = 2'd0,
    ST_CDET = 2'd1,
    ST_SYNC = 2'd2
  } sync_state_e;

  localparam logic [7:0] K28_5_BYTE = 8'hBC;

  localparam int DEF_COMMA_CNT  = 3;
  localparam int DEF_ERR_THRESH = 4;
  localparam int DEF_GOOD_CNT   = 4;

endpackage

// File: rtl/dec_sync_errcnt.sv
// 16-bit saturating event counter with synchronous clear.
module dec_sync_errcnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  input  logic        clr_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q, cnt_d;

  // Clear wins over the old value, but a coincident hit still counts.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    if (inc_i && cnt_d != 16'hFFFF) cnt_d = cnt_d + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dec_sync_ctrl.sv
// Comma acquire/lose-sync FSM and RD feedback after the 8b/10b decoder.
// Optional error counter: define DEC_SYNC_ERR_CNT_EN.
module dec_sync_ctrl
  import dec_sync_pkg::*;
#(
  parameter int COMMA_CNT  = DEF_COMMA_CNT,
  parameter int ERR_THRESH = DEF_ERR_THRESH,
  parameter int GOOD_CNT   = DEF_GOOD_CNT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sym_valid,
  input  logic [7:0]  datout,
  input  logic        kout,
  input  logic        code_err,
  input  logic        disp_err,
  input  logic        rdispout,
  output logic        rdispin,
  output logic [7:0]  rx_data,
  output logic        rx_k,
  output logic        rx_valid,
  output logic        sync_ok,
  output logic [1:0]  sync_state,
  input  logic        err_clr,
  output logic [15:0] err_cnt
);

  localparam int CW = $clog2(COMMA_CNT + 1);
  localparam int BW = $clog2(ERR_THRESH + 1);
  localparam int GW = $clog2(GOOD_CNT + 1);
  localparam logic [CW-1:0] CMAX = CW'(COMMA_CNT);
  localparam logic [BW-1:0] BMAX = BW'(ERR_THRESH);
  localparam logic [GW-1:0] GMAX = GW'(GOOD_CNT);

  sync_state_e   state_q, state_d;
  logic [CW-1:0] comma_q, comma_d;
  logic [BW-1:0] bad_q, bad_d;
  logic [GW-1:0] good_q, good_d;
  logic          rd_q, rd_d;
  logic [7:0]    data_q, data_d;
  logic          k_q, k_d;
  logic          vld_q, vld_d;

  logic bad_sym, ok_sym, comma;

  assign bad_sym = sym_valid & (code_err | disp_err);
  assign ok_sym  = sym_valid & ~(code_err | disp_err);
  assign comma   = ok_sym & kout & (datout == K28_5_BYTE);

  always_comb begin
    state_d = state_q;
    comma_d = comma_q;
    bad_d   = bad_q;
    good_d  = good_q;
    case (state_q)
      ST_LOS: begin
        if (comma) begin
          comma_d = CW'(1);
          bad_d   = '0;
          good_d  = '0;
          state_d = (COMMA_CNT <= 1) ? ST_SYNC : ST_CDET;
        end
      end
      ST_CDET: begin
        if (bad_sym) begin
          state_d = ST_LOS;
        end else if (comma) begin
          if (comma_q != CMAX) comma_d = comma_q + CW'(1);
          if (comma_d == CMAX) begin
            state_d = ST_SYNC;
            bad_d   = '0;
            good_d  = '0;
          end
        end
      end
      ST_SYNC: begin
        if (bad_sym) begin
          good_d = '0;
          if (bad_q != BMAX) bad_d = bad_q + BW'(1);
          if (bad_d == BMAX) state_d = ST_LOS;
        end else if (ok_sym) begin
          if (good_q != GMAX) good_d = good_q + GW'(1);
          // A clean run retires one bad credit.
          if (good_d == GMAX && bad_q != '0) begin
            bad_d  = bad_q - BW'(1);
            good_d = '0;
          end
        end
      end
      default: state_d = ST_LOS;
    endcase
  end

  always_comb begin
    rd_d = ok_sym ? rdispout : rd_q;
    if (state_d == ST_LOS && state_q != ST_LOS) rd_d = 1'b0;
    vld_d  = ok_sym & (state_d == ST_SYNC);
    data_d = vld_d ? datout : data_q;
    k_d    = vld_d ? kout : k_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOS;
      comma_q <= '0;
      bad_q   <= '0;
      good_q  <= '0;
      rd_q    <= 1'b0;
      data_q  <= '0;
      k_q     <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      comma_q <= comma_d;
      bad_q   <= bad_d;
      good_q  <= good_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      k_q     <= k_d;
      vld_q   <= vld_d;
    end
  end

  assign rdispin    = rd_q;
  assign rx_data    = data_q;
  assign rx_k       = k_q;
  assign rx_valid   = vld_q;
  assign sync_ok    = (state_q == ST_SYNC);
  assign sync_state = state_q;

`ifdef DEC_SYNC_ERR_CNT_EN
  dec_sync_errcnt u_errcnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (bad_sym),
    .clr_i (err_clr),
    .cnt_o (err_cnt)
  );
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif

endmodule
